// File: rtl/ysyx_22040386_lsu_if.sv
// Signal bundle between the MEM stage, the load/store unit, the data bus and the CLINT port.
// The slave modport is the LSU's view; the master modport is the surrounding system's view.
`timescale 1ns/1ps
interface ysyx_22040386_lsu_if #(
  parameter int XLEN = 64
);
  logic              i_LSU_valid;
  logic              o_LSU_ready;
  logic              i_LSU_we;
  logic [2:0]        i_LSU_funct3;
  logic [63:0]       i_LSU_addr;
  logic [XLEN-1:0]   i_LSU_wdata;
  logic              o_LSU_done;
  logic [XLEN-1:0]   o_LSU_rdata;
  logic              o_LSU_misalign;
  logic              o_LSU_bus_req;
  logic              o_LSU_bus_we;
  logic [63:0]       o_LSU_bus_addr;
  logic [XLEN-1:0]   o_LSU_bus_wdata;
  logic [XLEN/8-1:0] o_LSU_bus_wmask;
  logic              i_LSU_bus_ack;
  logic [XLEN-1:0]   i_LSU_bus_rdata;
  logic              o_LSU_clint_ren;
  logic              o_LSU_clint_wen;
  logic [63:0]       o_LSU_clint_addr;
  logic [XLEN-1:0]   o_LSU_clint_wdata;
  logic [XLEN-1:0]   i_LSU_clint_rdata;

  modport slave (
    input  i_LSU_valid, i_LSU_we, i_LSU_funct3, i_LSU_addr, i_LSU_wdata,
    input  i_LSU_bus_ack, i_LSU_bus_rdata, i_LSU_clint_rdata,
    output o_LSU_ready, o_LSU_done, o_LSU_rdata, o_LSU_misalign,
    output o_LSU_bus_req, o_LSU_bus_we, o_LSU_bus_addr, o_LSU_bus_wdata, o_LSU_bus_wmask,
    output o_LSU_clint_ren, o_LSU_clint_wen, o_LSU_clint_addr, o_LSU_clint_wdata
  );

  modport master (
    output i_LSU_valid, i_LSU_we, i_LSU_funct3, i_LSU_addr, i_LSU_wdata,
    output i_LSU_bus_ack, i_LSU_bus_rdata, i_LSU_clint_rdata,
    input  o_LSU_ready, o_LSU_done, o_LSU_rdata, o_LSU_misalign,
    input  o_LSU_bus_req, o_LSU_bus_we, o_LSU_bus_addr, o_LSU_bus_wdata, o_LSU_bus_wmask,
    input  o_LSU_clint_ren, o_LSU_clint_wen, o_LSU_clint_addr, o_LSU_clint_wdata
  );
endinterface

// File: rtl/ysyx_22040386_lsu.sv
// Multi-cycle load/store unit: one operation at a time, routed to the data bus or the CLINT,
// with alignment checking, byte-lane placement of stores and extension of load results.
`timescale 1ns/1ps
module ysyx_22040386_lsu #(
  parameter int          XLEN       = 64,
  parameter logic [63:0] CLINT_BASE = 64'h200_0000,
  parameter logic [63:0] CLINT_SIZE = 64'h1_0000
) (
  input logic                  i_LSU_clk,
  input logic                  i_LSU_rst,
  ysyx_22040386_lsu_if.slave   lsu
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BUS, CLINT, RESP} state_t;

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OFFW-1:0] o);
    logic [7:0] base;
    case (sz)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return NB'(base) << o;
  endfunction

  // Extension is done in a 64-bit scratch value so the same code serves XLEN=32 and 64.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    logic [63:0] r;
    logic [63:0] v;
    r = 64'(raw);
    case (f3[1:0])
      2'd0:    v = f3[2] ? {56'b0, r[7:0]}  : {{56{r[7]}},  r[7:0]};
      2'd1:    v = f3[2] ? {48'b0, r[15:0]} : {{48{r[15]}}, r[15:0]};
      2'd2:    v = f3[2] ? {32'b0, r[31:0]} : {{32{r[31]}}, r[31:0]};
      default: v = r;
    endcase
    return v[XLEN-1:0];
  endfunction

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [63:0]       bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [NB-1:0]     bus_wmask_q, bus_wmask_d;
  logic              clint_ren_q, clint_ren_d;
  logic              clint_wen_q, clint_wen_d;
  logic [63:0]       clint_addr_q, clint_addr_d;
  logic [XLEN-1:0]   clint_wdata_q, clint_wdata_d;

  logic [1:0]        size;
  logic [OFFW-1:0]   off;
  logic              illegal, misaligned, in_clint;

  assign size = lsu.i_LSU_funct3[1:0];
  assign off  = lsu.i_LSU_addr[OFFW-1:0];

  always_comb begin
    illegal = (lsu.i_LSU_funct3 == 3'b111) || ((XLEN == 32) && (size == 2'b11));
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = lsu.i_LSU_addr[0];
      2'd2:    misaligned = |lsu.i_LSU_addr[1:0];
      default: misaligned = |lsu.i_LSU_addr[2:0];
    endcase
    in_clint = (lsu.i_LSU_addr >= CLINT_BASE) && (lsu.i_LSU_addr < CLINT_BASE + CLINT_SIZE);
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    done_d        = done_q;
    misalign_d    = misalign_q;
    rdata_d       = rdata_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_wmask_d   = bus_wmask_q;
    clint_ren_d   = clint_ren_q;
    clint_wen_d   = clint_wen_q;
    clint_addr_d  = clint_addr_q;
    clint_wdata_d = clint_wdata_q;
    case (state_q)
      IDLE: begin
        if (lsu.i_LSU_valid) begin
          we_d     = lsu.i_LSU_we;
          funct3_d = lsu.i_LSU_funct3;
          off_d    = off;
          if (illegal || misaligned) begin
            state_d    = RESP;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else if (in_clint) begin
            state_d       = CLINT;
            clint_ren_d   = ~lsu.i_LSU_we;
            clint_wen_d   = lsu.i_LSU_we;
            clint_addr_d  = lsu.i_LSU_addr;
            clint_wdata_d = lsu.i_LSU_wdata;
          end else begin
            state_d     = BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = lsu.i_LSU_we;
            bus_addr_d  = {lsu.i_LSU_addr[63:OFFW], {OFFW{1'b0}}};
            bus_wdata_d = lsu.i_LSU_wdata << {off, 3'b000};
            bus_wmask_d = lane_mask(size, off);
          end
        end
      end
      BUS: begin
        if (lsu.i_LSU_bus_ack) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (!we_q) rdata_d = load_ext(lsu.i_LSU_bus_rdata >> {off_q, 3'b000}, funct3_q);
        end
      end
      CLINT: begin
        // The CLINT answers combinationally on the registered address, so one strobe cycle suffices.
        state_d     = RESP;
        clint_ren_d = 1'b0;
        clint_wen_d = 1'b0;
        done_d      = 1'b1;
        if (!we_q) rdata_d = load_ext(lsu.i_LSU_clint_rdata, funct3_q);
      end
      default: begin
        state_d    = IDLE;
        done_d     = 1'b0;
        misalign_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_LSU_clk) begin
    if (i_LSU_rst) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      misalign_q    <= 1'b0;
      rdata_q       <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_wmask_q   <= '0;
      clint_ren_q   <= 1'b0;
      clint_wen_q   <= 1'b0;
      clint_addr_q  <= '0;
      clint_wdata_q <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      misalign_q    <= misalign_d;
      rdata_q       <= rdata_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_wmask_q   <= bus_wmask_d;
      clint_ren_q   <= clint_ren_d;
      clint_wen_q   <= clint_wen_d;
      clint_addr_q  <= clint_addr_d;
      clint_wdata_q <= clint_wdata_d;
    end
    we_q     <= we_d;
    funct3_q <= funct3_d;
    off_q    <= off_d;
  end

  assign lsu.o_LSU_ready       = (state_q == IDLE);
  assign lsu.o_LSU_done        = done_q;
  assign lsu.o_LSU_misalign    = misalign_q;
  assign lsu.o_LSU_rdata       = rdata_q;
  assign lsu.o_LSU_bus_req     = bus_req_q;
  assign lsu.o_LSU_bus_we      = bus_we_q;
  assign lsu.o_LSU_bus_addr    = bus_addr_q;
  assign lsu.o_LSU_bus_wdata   = bus_wdata_q;
  assign lsu.o_LSU_bus_wmask   = bus_wmask_q;
  assign lsu.o_LSU_clint_ren   = clint_ren_q;
  assign lsu.o_LSU_clint_wen   = clint_wen_q;
  assign lsu.o_LSU_clint_addr  = clint_addr_q;
  assign lsu.o_LSU_clint_wdata = clint_wdata_q;
endmodule

// File: doc/ysyx_22040386_lsu.md
# ysyx_22040386_lsu

Parametrised, multi-cycle load/store unit that replaces the combinational memory-access stage of the pipeline. It accepts one memory operation at a time from the MEM stage over a valid/ready handshake and checks alignment. It routes the access to either the data bus (valid/ack handshake, variable latency) or the CLINT register port, then returns lane-extracted, sign/zero-extended load data with a one-cycle done pulse. While it is busy, the pipeline is held by `o_LSU_ready` low.

## Interface
Parameters:
- `XLEN`, 64: data width; 32 or 64 only.
- `CLINT_BASE`, 64'h200_0000: first byte address of the CLINT window.
- `CLINT_SIZE`, 64'h1_0000: size of the CLINT window in bytes.

Ports:
- `i_LSU_clk` in 1: the only clock; all state updates on its rising edge.
- `i_LSU_rst` in 1: reset, synchronous and active-high.
- `i_LSU_valid` in 1: an operation is offered this cycle.
- `o_LSU_ready` in/out: out 1, unit is idle and can accept an operation.
- `i_LSU_we` in 1: 1 = store, 0 = load.
- `i_LSU_funct3` in 3: RISC-V funct3. Bits [1:0] give the size (B/H/W/D). Bit 2 selects unsigned loads.
- `i_LSU_addr` in 64: byte address.
- `i_LSU_wdata` in XLEN: store data, right-aligned.
- `o_LSU_done` out 1: one-cycle completion pulse.
- `o_LSU_rdata` out XLEN: extended load data; valid only while `o_LSU_done`=1 and the operation was a load.
- `o_LSU_misalign` out 1: qualifies `o_LSU_done`; the access was misaligned or illegal and was not performed.
- `o_LSU_bus_req` out 1: bus request, held until acknowledged.
- `o_LSU_bus_we` out 1: bus write enable.
- `o_LSU_bus_addr` out 64: bus address, aligned down to XLEN/8 bytes.
- `o_LSU_bus_wdata` out XLEN: store data shifted into its byte lanes.
- `o_LSU_bus_wmask` out XLEN/8: byte-lane strobe.
- `i_LSU_bus_ack` in 1: bus completion; read data is valid in the same cycle.
- `i_LSU_bus_rdata` in XLEN: bus read data, full word.
- `o_LSU_clint_ren` out 1: CLINT read strobe.
- `o_LSU_clint_wen` out 1: CLINT write strobe.
- `o_LSU_clint_addr` out 64: CLINT address, unaligned passthrough.
- `o_LSU_clint_wdata` out XLEN: CLINT write data, unshifted.
- `i_LSU_clint_rdata` in XLEN: CLINT read data, combinational on `o_LSU_clint_addr`.

## Operation
- FSM states: IDLE, BUS, CLINT, RESP.
- `o_LSU_ready` is 1 exactly when the state is IDLE.
- An operation is accepted in IDLE when `i_LSU_valid`=1. The unit registers we, funct3, addr and wdata.
- Decode of the accepted operation, in priority order:
  - Illegal: size=D with XLEN=32, or funct3=3'b111. Go to RESP with misalign=1.
  - Misaligned: any of addr[size-1:0] nonzero. Go to RESP with misalign=1. No bus or CLINT strobe is issued.
  - Address in [CLINT_BASE, CLINT_BASE+CLINT_SIZE): go to CLINT.
  - Otherwise: go to BUS.
- BUS state:
  - `o_LSU_bus_req`=1 with stable addr/we/wdata/wmask until `i_LSU_bus_ack`.
  - On ack: capture `i_LSU_bus_rdata` if the operation is a load, then go to RESP.
  - Ack while req=0 is ignored.
- CLINT state: asserts ren or wen for exactly one cycle. On a load, samples `i_LSU_clint_rdata` in that cycle. Then goes to RESP.
- RESP state: `o_LSU_done`=1 for one cycle, then return to IDLE. A new operation cannot be accepted in RESP.
- Byte-lane offset: off = addr[log2(XLEN/8)-1:0].
- Store lanes: wmask = ({1,3,F,FF}[size]) << off. wdata = `i_LSU_wdata` << (8*off).
- Load extract: field = rdata >> (8*off), truncated to the size. Sign-extended when funct3[2]=0, zero-extended when funct3[2]=1. Size D passes through unchanged.
- CLINT accesses are not lane-shifted; the CLINT returns right-aligned data. Extension still applies.

## Timing
- All outputs reset to 0. The state resets to IDLE, so `o_LSU_ready`=1 in the first cycle after reset.
- Reset asserted mid-operation aborts the operation: bus_req drops the next cycle, and no done pulse is produced.
- Latency, counted from the accept edge (cycle 0):
  - Bus access with ack in the first BUS cycle: req in cycle 1, done in cycle 2.
  - Each cycle of ack delay adds one cycle.
  - CLINT access: strobe in cycle 1, done in cycle 2.
  - Misaligned/illegal: done with misalign=1 in cycle 1.
- Bus, CLINT and done outputs are registered state decodes. There is no combinational path from `i_LSU_valid` to any output other than none. `o_LSU_ready` depends only on state.
- `o_LSU_rdata` holds its value after done until the next load completes. Stores do not alter it.

## Test plan
- XLEN=64, load lb at addr 0x8000_0003, bus ack after 3 wait cycles with rdata 0x1122_3344_8566_7788 -> done in cycle 5, rdata = 0xFFFF_FFFF_FFFF_FF85. With lbu -> 0x85.
- sh of 0xABCD at 0x8000_0006 -> bus_req with wmask 8'hC0, wdata 0xABCD_0000_0000_0000, addr 0x8000_0000. Held stable until ack.
- lw at 0x8000_0002 -> done with misalign=1 in cycle 1. bus_req and clint strobes stay 0 throughout.
- ld at 0x200_BFF8 with clint_rdata 0x1234 -> clint_ren for exactly 1 cycle, bus_req=0, done in cycle 2 with rdata 0x1234.
- Back-to-back: valid held high continuously -> ready=0 during BUS/RESP, each operation accepted only in IDLE, one done per operation.
- Reset asserted in BUS while ack is withheld -> bus_req=0 and ready=1 after the reset edge, no done pulse. A following sd completes normally.
